// File: rtl/vendor_pkg.sv
// Shared types and constants for the ticket vending machine.
// Consumed by multi_vendor (optional cancel feature: VENDOR_CANCEL_EN).
package vendor_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EVAL     = 3'd1,
        TICKET   = 3'd2,
        CHG_TEN  = 3'd3,
        CHG_FIVE = 3'd4,
        CHG_ONE  = 3'd5
    } state_e;

    localparam int unsigned COIN_ONE  = 1;
    localparam int unsigned COIN_FIVE = 5;
    localparam int unsigned COIN_TEN  = 10;

    // Headroom bits so a credit plus one cycle of coins cannot wrap before saturation.
    localparam int unsigned SUM_GUARD = 5;

    // First dispense state at or after 'from' that still has something to emit; IDLE if none.
    function automatic state_e first_state(
        input state_e from,
        input logic   has_tk,
        input logic   has_te,
        input logic   has_fi,
        input logic   has_on
    );
        state_e s;
        s = IDLE;
        if (has_on && (from <= CHG_ONE))  s = CHG_ONE;
        if (has_fi && (from <= CHG_FIVE)) s = CHG_FIVE;
        if (has_te && (from <= CHG_TEN))  s = CHG_TEN;
        if (has_tk && (from <= TICKET))   s = TICKET;
        return s;
    endfunction

endpackage

// File: rtl/multi_vendor_pulse_train.sv
// pulse_train: loads a count and requests one pulse every other cycle until drained.
// fire_c marks the cycle whose edge issues a pulse; empty_c means drained and spaced.
module pulse_train #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_cnt,
    output logic          fire_c,
    output logic          empty_c
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          gap_q, gap_d;

    assign fire_c  = (cnt_q != '0) && !gap_q;
    assign empty_c = (cnt_q == '0) && !gap_q;

    // gap_q forces a low cycle after every issued pulse
    always_comb begin
        cnt_d = cnt_q;
        gap_d = 1'b0;
        if (load) begin
            cnt_d = load_cnt;
        end else if (fire_c) begin
            cnt_d = cnt_q - DW'(1);
            gap_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            gap_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/multi_vendor.sv
// Ticket vending machine: coin credit, fare evaluation, ticket and greedy change dispensing.
// Optional feature macro: VENDOR_CANCEL_EN (cancel edge refunds the current credit).
module multi_vendor #(
    parameter int unsigned DW         = 8,
    parameter int unsigned MYID       = 16,
    parameter int unsigned BASE_PRICE = 2,
    parameter int unsigned MAX_COUNT  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] input_dest,
    input  logic [DW-1:0] input_count,
    input  logic          coin_one_in_pulse,
    input  logic          coin_five_in_pulse,
    input  logic          coin_ten_in_pulse,
    input  logic          done,
    input  logic          cancel,
    output logic          ticket_pulse,
    output logic          coin_ten_out_pulse,
    output logic          coin_five_out_pulse,
    output logic          coin_one_out_pulse,
    output logic          busy,
    output logic [DW-1:0] credit
);

    import vendor_pkg::*;

    localparam int unsigned CW = DW + SUM_GUARD;
    localparam int unsigned PW = 2 * DW;

    state_e        state_q, state_d;
    logic [DW-1:0] credit_q, credit_d;
    logic [DW-1:0] dest_q, dest_d;
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] tens_q, tens_d;
    logic [DW-1:0] fives_q, fives_d;
    logic [DW-1:0] ones_q, ones_d;
    logic          done_prev_q, done_prev_d;
    logic          armed_q, armed_d;
    logic          ticket_pulse_q, ticket_pulse_d;
    logic          ten_pulse_q, ten_pulse_d;
    logic          five_pulse_q, five_pulse_d;
    logic          one_pulse_q, one_pulse_d;
    logic          busy_q, busy_d;

    logic          done_rise_c;
    logic [CW-1:0] sum_wide_c;
    logic [DW-1:0] coin_sum_c;
    logic [DW-1:0] diff_c;
    logic [PW-1:0] unit_c;
    logic [PW-1:0] total_c;
    logic          valid_c;
    logic [DW-1:0] change_c;
    logic [DW-1:0] tickets_c;
    logic [DW-1:0] split_in_c;
    logic [DW-1:0] tens_c, rem_c, fives_c, ones_c;
    state_e        nxt_c;
    logic          enter_c;
    logic          load_c;
    logic [DW-1:0] load_cnt_c;
    logic          fire_c;
    logic          empty_c;

    // armed_q masks the first cycle after reset so a level held through reset is not an edge
    assign done_rise_c = done && !done_prev_q && armed_q;

`ifdef VENDOR_CANCEL_EN
    logic cancel_prev_q, cancel_prev_d;
    logic cancel_rise_c;

    assign cancel_prev_d = cancel;
    assign cancel_rise_c = cancel && !cancel_prev_q && armed_q;

    always_ff @(posedge clk) begin
        if (rst) cancel_prev_q <= 1'b0;
        else     cancel_prev_q <= cancel_prev_d;
    end

    assign split_in_c = (state_q == EVAL) ? change_c : coin_sum_c;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign split_in_c    = change_c;
`endif

    // Credit plus this cycle's coins, saturating at the register maximum
    always_comb begin
        sum_wide_c = CW'(credit_q)
                   + (coin_ten_in_pulse  ? CW'(COIN_TEN)  : CW'(0))
                   + (coin_five_in_pulse ? CW'(COIN_FIVE) : CW'(0))
                   + (coin_one_in_pulse  ? CW'(COIN_ONE)  : CW'(0));
        coin_sum_c = (sum_wide_c > CW'({DW{1'b1}})) ? {DW{1'b1}} : DW'(sum_wide_c);
    end

    // Fare evaluation on the captured request
    always_comb begin
        diff_c    = (dest_q >= DW'(MYID)) ? (dest_q - DW'(MYID)) : (DW'(MYID) - dest_q);
        unit_c    = PW'(BASE_PRICE) + PW'(diff_c);
        total_c   = unit_c * PW'(count_q);
        valid_c   = (dest_q != DW'(MYID)) && (count_q != '0)
                 && (count_q <= DW'(MAX_COUNT)) && (total_c <= PW'(credit_q));
        change_c  = valid_c ? (credit_q - DW'(total_c)) : credit_q;
        tickets_c = valid_c ? count_q : '0;
    end

    // Greedy coin split shared by evaluation and cancel refund
    always_comb begin
        tens_c  = split_in_c / DW'(COIN_TEN);
        rem_c   = split_in_c % DW'(COIN_TEN);
        fives_c = rem_c / DW'(COIN_FIVE);
        ones_c  = rem_c % DW'(COIN_FIVE);
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        dest_d     = dest_q;
        count_d    = count_q;
        tens_d     = tens_q;
        fives_d    = fives_q;
        ones_d     = ones_q;
        nxt_c      = IDLE;
        enter_c    = 1'b0;
        load_c     = 1'b0;
        load_cnt_c = '0;

        case (state_q)
            IDLE: begin
                credit_d = coin_sum_c;
                if (done_rise_c) begin
                    dest_d  = input_dest;
                    count_d = input_count;
                    state_d = EVAL;
                end
`ifdef VENDOR_CANCEL_EN
                else if (cancel_rise_c && (coin_sum_c != '0)) begin
                    tens_d  = tens_c;
                    fives_d = fives_c;
                    ones_d  = ones_c;
                    nxt_c   = first_state(CHG_TEN, 1'b0, tens_c != '0,
                                          fives_c != '0, ones_c != '0);
                    enter_c = 1'b1;
                end
`endif
            end
            EVAL: begin
                credit_d = change_c;
                tens_d   = tens_c;
                fives_d  = fives_c;
                ones_d   = ones_c;
                nxt_c    = first_state(TICKET, tickets_c != '0, tens_c != '0,
                                       fives_c != '0, ones_c != '0);
                enter_c  = 1'b1;
            end
            TICKET: begin
                if (empty_c) begin
                    nxt_c   = first_state(CHG_TEN, 1'b0, tens_q != '0,
                                          fives_q != '0, ones_q != '0);
                    enter_c = 1'b1;
                end
            end
            CHG_TEN: begin
                if (fire_c) credit_d = credit_q - DW'(COIN_TEN);
                if (empty_c) begin
                    nxt_c   = first_state(CHG_FIVE, 1'b0, 1'b0,
                                          fives_q != '0, ones_q != '0);
                    enter_c = 1'b1;
                end
            end
            CHG_FIVE: begin
                if (fire_c) credit_d = credit_q - DW'(COIN_FIVE);
                if (empty_c) begin
                    nxt_c   = first_state(CHG_ONE, 1'b0, 1'b0, 1'b0, ones_q != '0);
                    enter_c = 1'b1;
                end
            end
            CHG_ONE: begin
                if (fire_c) credit_d = credit_q - DW'(COIN_ONE);
                if (empty_c) enter_c = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Jump straight to the next non-empty stage and preload its count
        if (enter_c) begin
            state_d = nxt_c;
            if (nxt_c == IDLE) begin
                credit_d = '0;
            end else begin
                load_c = 1'b1;
                case (nxt_c)
                    TICKET:   load_cnt_c = tickets_c;
                    CHG_TEN:  load_cnt_c = tens_d;
                    CHG_FIVE: load_cnt_c = fives_d;
                    CHG_ONE:  load_cnt_c = ones_d;
                    default:  load_cnt_c = '0;
                endcase
            end
        end
    end

    always_comb begin
        done_prev_d    = done;
        armed_d        = 1'b1;
        ticket_pulse_d = fire_c && (state_q == TICKET);
        ten_pulse_d    = fire_c && (state_q == CHG_TEN);
        five_pulse_d   = fire_c && (state_q == CHG_FIVE);
        one_pulse_d    = fire_c && (state_q == CHG_ONE);
        busy_d         = (state_d != IDLE);
    end

    pulse_train #(
        .DW (DW)
    ) u_pulse_train (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .load_cnt (load_cnt_c),
        .fire_c   (fire_c),
        .empty_c  (empty_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            dest_q         <= '0;
            count_q        <= '0;
            tens_q         <= '0;
            fives_q        <= '0;
            ones_q         <= '0;
            done_prev_q    <= 1'b0;
            armed_q        <= 1'b0;
            ticket_pulse_q <= 1'b0;
            ten_pulse_q    <= 1'b0;
            five_pulse_q   <= 1'b0;
            one_pulse_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            dest_q         <= dest_d;
            count_q        <= count_d;
            tens_q         <= tens_d;
            fives_q        <= fives_d;
            ones_q         <= ones_d;
            done_prev_q    <= done_prev_d;
            armed_q        <= armed_d;
            ticket_pulse_q <= ticket_pulse_d;
            ten_pulse_q    <= ten_pulse_d;
            five_pulse_q   <= five_pulse_d;
            one_pulse_q    <= one_pulse_d;
            busy_q         <= busy_d;
        end
    end

    assign ticket_pulse        = ticket_pulse_q;
    assign coin_ten_out_pulse  = ten_pulse_q;
    assign coin_five_out_pulse = five_pulse_q;
    assign coin_one_out_pulse  = one_pulse_q;
    assign busy                = busy_q;
    assign credit              = credit_q;

endmodule

// File: tb/tb_multi_vendor.sv
// Directed bench for multi_vendor: vector table of whole transactions plus corner sequences.
module tb_multi_vendor;

    logic       clk;
    logic       rst;
    logic [7:0] input_dest;
    logic [7:0] input_count;
    logic       coin_one_in_pulse;
    logic       coin_five_in_pulse;
    logic       coin_ten_in_pulse;
    logic       done;
    logic       cancel;
    logic       ticket_pulse;
    logic       coin_ten_out_pulse;
    logic       coin_five_out_pulse;
    logic       coin_one_out_pulse;
    logic       busy;
    logic [7:0] credit;

    int checks = 0;
    int errors = 0;

    multi_vendor dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_dest          (input_dest),
        .input_count         (input_count),
        .coin_one_in_pulse   (coin_one_in_pulse),
        .coin_five_in_pulse  (coin_five_in_pulse),
        .coin_ten_in_pulse   (coin_ten_in_pulse),
        .done                (done),
        .cancel              (cancel),
        .ticket_pulse        (ticket_pulse),
        .coin_ten_out_pulse  (coin_ten_out_pulse),
        .coin_five_out_pulse (coin_five_out_pulse),
        .coin_one_out_pulse  (coin_one_out_pulse),
        .busy                (busy),
        .credit              (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running pulse totals and spacing/overlap violations
    int n_tk = 0, n_te = 0, n_fi = 0, n_on = 0, viol = 0;
    bit prev_any = 1'b0;
    always @(negedge clk) begin
        int s;
        s = int'(ticket_pulse) + int'(coin_ten_out_pulse)
          + int'(coin_five_out_pulse) + int'(coin_one_out_pulse);
        if (ticket_pulse)        n_tk++;
        if (coin_ten_out_pulse)  n_te++;
        if (coin_five_out_pulse) n_fi++;
        if (coin_one_out_pulse)  n_on++;
        if (s > 1) viol++;
        if (s > 0 && prev_any) viol++;
        prev_any = (s > 0);
    end

    typedef struct {
        int         n_ten;
        int         n_five;
        int         n_one;
        logic [7:0] dest;
        logic [7:0] cnt;
        bit         use_cancel;
        int         e_tk;
        int         e_te;
        int         e_fi;
        int         e_on;
        int         e_credit;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic coin(input int k);
        @(negedge clk);
        coin_ten_in_pulse  = (k == 10);
        coin_five_in_pulse = (k == 5);
        coin_one_in_pulse  = (k == 1);
        @(negedge clk);
        coin_ten_in_pulse  = 1'b0;
        coin_five_in_pulse = 1'b0;
        coin_one_in_pulse  = 1'b0;
    endtask

    task automatic commit(input logic [7:0] d, input logic [7:0] c, input bit use_cancel);
        @(negedge clk);
        input_dest  = d;
        input_count = c;
        if (use_cancel) cancel = 1'b1;
        else            done   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        done   = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic wait_idle(input string p);
        int cyc;
        cyc = 0;
        while (cyc < 400) begin
            if (!busy && cyc >= 3) break;
            @(negedge clk);
            cyc++;
        end
        check({p, "_idle_timeout"}, (cyc < 400) ? 1 : 0, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        int b_tk, b_te, b_fi, b_on, b_v;
        p = $sformatf("v%0d", idx);
        do_reset();
        check({p, "_reset_credit"}, int'(credit), 0);
        for (int i = 0; i < v.n_ten; i++)  coin(10);
        for (int i = 0; i < v.n_five; i++) coin(5);
        for (int i = 0; i < v.n_one; i++)  coin(1);
        check({p, "_credit_in"}, int'(credit), 10 * v.n_ten + 5 * v.n_five + v.n_one);
        b_tk = n_tk; b_te = n_te; b_fi = n_fi; b_on = n_on; b_v = viol;
        commit(v.dest, v.cnt, v.use_cancel);
        wait_idle(p);
        check({p, "_tickets"}, n_tk - b_tk, v.e_tk);
        check({p, "_tens"}, n_te - b_te, v.e_te);
        check({p, "_fives"}, n_fi - b_fi, v.e_fi);
        check({p, "_ones"}, n_on - b_on, v.e_on);
        check({p, "_credit_end"}, int'(credit), v.e_credit);
        check({p, "_busy_end"}, int'(busy), 0);
        check({p, "_spacing"}, viol - b_v, 0);
    endtask

    initial begin
        int b_tk, b_te, b_fi, b_on, b_v, cyc;
        rst = 1'b1;
        input_dest = '0;
        input_count = '0;
        coin_one_in_pulse = 1'b0;
        coin_five_in_pulse = 1'b0;
        coin_ten_in_pulse = 1'b0;
        done = 1'b0;
        cancel = 1'b0;

        //            ten five one dest   cnt   canc tk te fi on credit
        vecs[0] = '{1, 1, 0, 8'd20, 8'd2, 1'b0, 2, 0, 0, 3, 0};  // total 12, change 3
        vecs[1] = '{1, 0, 0, 8'd26, 8'd1, 1'b0, 0, 1, 0, 0, 0};  // total 12 > 10, refund
        vecs[2] = '{0, 1, 2, 8'd20, 8'd0, 1'b0, 0, 0, 1, 2, 0};  // count 0
        vecs[3] = '{0, 1, 2, 8'd20, 8'd5, 1'b0, 0, 0, 1, 2, 0};  // count above max
        vecs[4] = '{0, 1, 2, 8'd16, 8'd1, 1'b0, 0, 0, 1, 2, 0};  // own station
        vecs[5] = '{2, 0, 0, 8'd15, 8'd3, 1'b0, 3, 1, 0, 1, 0};  // total 9, change 11
        vecs[6] = '{2, 0, 0, 8'd18, 8'd4, 1'b0, 4, 0, 0, 4, 0};  // total 16, change 4
        vecs[7] = '{1, 0, 0, 8'd19, 8'd2, 1'b0, 2, 0, 0, 0, 0};  // exact fare
        vecs[8] = '{0, 1, 0, 8'd17, 8'd1, 1'b0, 1, 0, 0, 2, 0};  // total 3, change 2
`ifdef VENDOR_CANCEL_EN
        vecs[9] = '{1, 1, 1, 8'd20, 8'd1, 1'b1, 0, 1, 1, 1, 0};
`else
        vecs[9] = '{1, 1, 1, 8'd20, 8'd1, 1'b1, 0, 0, 0, 0, 16};
`endif

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_credit", int'(credit), 0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Coin and done edge during TICKET must not disturb the transaction
        do_reset();
        coin(10);
        coin(10);
        b_tk = n_tk; b_on = n_on; b_v = viol;
        commit(8'd18, 8'd4, 1'b0);
        cyc = 0;
        while (!ticket_pulse && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("tkt_first_pulse_timeout", (cyc < 50) ? 1 : 0, 1);
        coin_ten_in_pulse = 1'b1;
        done = 1'b1;
        @(negedge clk);
        coin_ten_in_pulse = 1'b0;
        done = 1'b0;
        wait_idle("tkt_disturb");
        check("tkt_disturb_tickets", n_tk - b_tk, 4);
        check("tkt_disturb_ones", n_on - b_on, 4);
        check("tkt_disturb_credit", int'(credit), 0);
        repeat (5) @(negedge clk);
        check("tkt_disturb_no_retrigger", int'(busy), 0);
        check("tkt_disturb_spacing", viol - b_v, 0);

        // Saturation, then reset in the middle of change dispensing
        do_reset();
        for (int i = 0; i < 25; i++) coin(10);
        check("sat_credit_250", int'(credit), 250);
        coin(10);
        check("sat_credit_255", int'(credit), 255);
        b_tk = n_tk; b_te = n_te;
        commit(8'd17, 8'd1, 1'b0);
        cyc = 0;
        while (!coin_one_out_pulse && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("sat_one_pulse_timeout", (cyc < 400) ? 1 : 0, 1);
        check("sat_tickets", n_tk - b_tk, 1);
        check("sat_tens", n_te - b_te, 25);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ticket", int'(ticket_pulse), 0);
        check("midrst_outs", int'(coin_ten_out_pulse) + int'(coin_five_out_pulse)
                             + int'(coin_one_out_pulse), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_credit", int'(credit), 0);
        rst = 1'b0;
        b_tk = n_tk; b_te = n_te; b_fi = n_fi; b_on = n_on;
        repeat (20) @(negedge clk);
        check("midrst_no_more_pulses", (n_tk - b_tk) + (n_te - b_te) + (n_fi - b_fi)
                                       + (n_on - b_on), 0);
        check("midrst_idle", int'(busy), 0);

        // Levels held high through reset release are not edges
        @(negedge clk);
        rst = 1'b1;
        done = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        b_v = viol;
        repeat (5) @(negedge clk);
        check("held_done_busy", int'(busy), 0);
        check("held_done_credit", int'(credit), 0);
        done = 1'b0;
        cancel = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
